// File: rtl/motion_box_if.sv
// Delta-mask stream into motion_box plus the per-frame bounding-box result.
interface motion_box_if #(
    parameter int INPUT_WIDTH = 10,
    parameter int COORD_WIDTH = 10,
    parameter int COUNT_WIDTH = 20
) ();
    logic                   enable;
    logic                   sof;
    logic [INPUT_WIDTH-1:0] delta_pixel;
    logic [COUNT_WIDTH-1:0] min_count;
    logic [COORD_WIDTH-1:0] box_x_min;
    logic [COORD_WIDTH-1:0] box_x_max;
    logic [COORD_WIDTH-1:0] box_y_min;
    logic [COORD_WIDTH-1:0] box_y_max;
    logic [COUNT_WIDTH-1:0] box_count;
    logic                   box_found;
    logic                   box_valid;
    logic                   frame_abort;

    modport master (
        output enable, sof, delta_pixel, min_count,
        input  box_x_min, box_x_max, box_y_min, box_y_max,
               box_count, box_found, box_valid, frame_abort
    );

    modport slave (
        input  enable, sof, delta_pixel, min_count,
        output box_x_min, box_x_max, box_y_min, box_y_max,
               box_count, box_found, box_valid, frame_abort
    );
endinterface

// File: rtl/motion_box.sv
// Per-frame bounding box and active-pixel count of the delta motion mask.
// Define MOTION_BOX_NOISE_FILTER_EN to require two consecutive active pixels in a line.
//
// state | meaning
// IDLE  | waiting for an enabled sof pixel
// SCAN  | walking the frame, accumulating box and count
module motion_box #(
    parameter int INPUT_WIDTH  = 10,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int COORD_WIDTH  = 10,
    parameter int COUNT_WIDTH  = 20
) (
    input  logic        clk,
    input  logic        areset,
    motion_box_if.slave bus
);
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state;
    logic [COORD_WIDTH-1:0] x, y;
    logic [COORD_WIDTH-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [COUNT_WIDTH-1:0] acc_count;

    logic                   restart, beat, abort, pix_on, active, wrap, last, found;
    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic [COORD_WIDTH-1:0] base_x_min, base_x_max, base_y_min, base_y_max;
    logic [COORD_WIDTH-1:0] nx_x_min, nx_x_max, nx_y_min, nx_y_max;
    logic [COUNT_WIDTH-1:0] base_count, nx_count;
    logic                   unused_pixel_bits;

    assign unused_pixel_bits = ^bus.delta_pixel[INPUT_WIDTH-2:0];

`ifdef MOTION_BOX_NOISE_FILTER_EN
    logic prev_on;
`endif

    always_comb begin
        restart = bus.enable && bus.sof;
        beat    = bus.enable && (restart || state == SCAN);
        abort   = restart && state == SCAN;
        pix_on  = bus.delta_pixel[INPUT_WIDTH-1];
        // An sof pixel always starts from position (0,0) with fresh accumulators.
        cur_x      = restart ? '0 : x;
        cur_y      = restart ? '0 : y;
        base_x_min = restart ? '1 : acc_x_min;
        base_x_max = restart ? '0 : acc_x_max;
        base_y_min = restart ? '1 : acc_y_min;
        base_y_max = restart ? '0 : acc_y_max;
        base_count = restart ? '0 : acc_count;
`ifdef MOTION_BOX_NOISE_FILTER_EN
        active = pix_on && prev_on && !restart && cur_x != '0;
`else
        active = pix_on;
`endif
        nx_x_min = base_x_min;
        nx_x_max = base_x_max;
        nx_y_min = base_y_min;
        nx_y_max = base_y_max;
        nx_count = base_count;
        if (active) begin
            if (cur_x < base_x_min) nx_x_min = cur_x;
            if (cur_x > base_x_max) nx_x_max = cur_x;
            if (cur_y < base_y_min) nx_y_min = cur_y;
            if (cur_y > base_y_max) nx_y_max = cur_y;
            if (base_count != '1)   nx_count = base_count + COUNT_WIDTH'(1);
        end
        wrap  = cur_x == X_LAST;
        last  = wrap && cur_y == Y_LAST;
        found = nx_count >= bus.min_count;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            acc_x_min       <= '0;
            acc_x_max       <= '0;
            acc_y_min       <= '0;
            acc_y_max       <= '0;
            acc_count       <= '0;
            bus.box_x_min   <= '0;
            bus.box_x_max   <= '0;
            bus.box_y_min   <= '0;
            bus.box_y_max   <= '0;
            bus.box_count   <= '0;
            bus.box_found   <= 1'b0;
            bus.box_valid   <= 1'b0;
            bus.frame_abort <= 1'b0;
`ifdef MOTION_BOX_NOISE_FILTER_EN
            prev_on         <= 1'b0;
`endif
        end else begin
            bus.box_valid   <= 1'b0;
            bus.frame_abort <= abort;
            if (beat) begin
                acc_x_min <= nx_x_min;
                acc_x_max <= nx_x_max;
                acc_y_min <= nx_y_min;
                acc_y_max <= nx_y_max;
                acc_count <= nx_count;
`ifdef MOTION_BOX_NOISE_FILTER_EN
                prev_on   <= pix_on && !wrap;
`endif
                if (last) begin
                    state         <= IDLE;
                    x             <= '0;
                    y             <= '0;
                    bus.box_count <= nx_count;
                    bus.box_found <= found;
                    bus.box_x_min <= found ? nx_x_min : '0;
                    bus.box_x_max <= found ? nx_x_max : '0;
                    bus.box_y_min <= found ? nx_y_min : '0;
                    bus.box_y_max <= found ? nx_y_max : '0;
                    bus.box_valid <= !abort;
                end else begin
                    state <= SCAN;
                    if (wrap) begin
                        x <= '0;
                        y <= cur_y + COORD_WIDTH'(1);
                    end else begin
                        x <= cur_x + COORD_WIDTH'(1);
                        y <= cur_y;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_motion_box.sv
// Randomized bench for motion_box on an 8x6 frame, checked every cycle against a frame-buffer model.
module tb_motion_box;
    localparam int IW = 10, CW = 10, NW = 20;
    localparam int W = 8, H = 6, N = W * H;

    logic clk = 1'b0;
    logic areset;

    motion_box_if #(.INPUT_WIDTH(IW), .COORD_WIDTH(CW), .COUNT_WIDTH(NW)) bus ();

    motion_box #(
        .INPUT_WIDTH(IW), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
        .COORD_WIDTH(CW), .COUNT_WIDTH(NW)
    ) dut (
        .clk(clk),
        .areset(areset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int valid_seen = 0, abort_seen = 0;
    bit cmp_on = 1'b0;

    // Model: the frame's raw mask bits, judged as a whole when the last pixel arrives.
    bit in_frame;
    int pos;
    bit raw[N];
    bit frame_mask[N];
    int exp_x_min, exp_x_max, exp_y_min, exp_y_max, exp_count;
    bit exp_found, exp_valid, exp_abort;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_active(int i);
`ifdef MOTION_BOX_NOISE_FILTER_EN
        if (i % W == 0) return 1'b0;
        return raw[i] && raw[i-1];
`else
        return raw[i];
`endif
    endfunction

    task automatic model_reset();
        in_frame = 0; pos = 0;
        exp_x_min = 0; exp_x_max = 0; exp_y_min = 0; exp_y_max = 0;
        exp_count = 0; exp_found = 0; exp_valid = 0; exp_abort = 0;
    endtask

    task automatic finish_frame(int minc);
        int cnt = 0, xmn = (1 << CW) - 1, xmx = 0, ymn = (1 << CW) - 1, ymx = 0;
        for (int i = 0; i < N; i++) begin
            if (is_active(i)) begin
                cnt++;
                if (i % W < xmn) xmn = i % W;
                if (i % W > xmx) xmx = i % W;
                if (i / W < ymn) ymn = i / W;
                if (i / W > ymx) ymx = i / W;
            end
        end
        exp_count = cnt;
        exp_found = cnt >= minc;
        exp_x_min = exp_found ? xmn : 0;
        exp_x_max = exp_found ? xmx : 0;
        exp_y_min = exp_found ? ymn : 0;
        exp_y_max = exp_found ? ymx : 0;
    endtask

    task automatic model_step(bit en, bit s, bit b, int minc);
        exp_valid = 0;
        exp_abort = 0;
        if (!en) return;
        if (s) begin
            exp_abort = in_frame;
            in_frame = 1;
            pos = 0;
        end else if (!in_frame) begin
            return;
        end
        raw[pos] = b;
        if (pos == N - 1) begin
            finish_frame(minc);
            exp_valid = !exp_abort;
            in_frame = 0;
        end else begin
            pos++;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("box_valid",   bus.box_valid,   exp_valid);
            check("frame_abort", bus.frame_abort, exp_abort);
            check("box_found",   bus.box_found,   exp_found);
            check("box_count",   bus.box_count,   exp_count);
            check("box_x_min",   bus.box_x_min,   exp_x_min);
            check("box_x_max",   bus.box_x_max,   exp_x_max);
            check("box_y_min",   bus.box_y_min,   exp_y_min);
            check("box_y_max",   bus.box_y_max,   exp_y_max);
            if (bus.box_valid)   valid_seen++;
            if (bus.frame_abort) abort_seen++;
        end
    end

    task automatic cycle(bit en, bit s, bit b);
        logic [IW-1:0] px;
        px = IW'($urandom);
        px[IW-1] = b;
        bus.enable = en;
        bus.sof = s;
        bus.delta_pixel = px;
        @(posedge clk);
        model_step(en, s, b, int'(bus.min_count));
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixels(int n, int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max))
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle(1'b1, i == 0, frame_mask[i]);
        end
    endtask

    task automatic clear_mask();
        for (int i = 0; i < N; i++) frame_mask[i] = 0;
    endtask

    task automatic set_px(int px, int py);
        frame_mask[py * W + px] = 1;
    endtask

    task automatic expect_result(string tag, int xmn, int xmx, int ymn, int ymx, int cnt, bit fnd);
        check({tag, " x_min"}, bus.box_x_min, xmn);
        check({tag, " x_max"}, bus.box_x_max, xmx);
        check({tag, " y_min"}, bus.box_y_min, ymn);
        check({tag, " y_max"}, bus.box_y_max, ymx);
        check({tag, " count"}, bus.box_count, cnt);
        check({tag, " found"}, bus.box_found, fnd);
        check({tag, " model count"}, exp_count, cnt);
        check({tag, " model x_min"}, exp_x_min, xmn);
    endtask

    initial begin
        int v0, a0;
        areset = 1'b1;
        bus.enable = 1'b0;
        bus.sof = 1'b0;
        bus.delta_pixel = '0;
        bus.min_count = '0;
        model_reset();
        clear_mask();
        cmp_on = 1'b1;
        idle(2);
        expect_result("reset", 0, 0, 0, 0, 0, 0);
        check("reset valid", bus.box_valid, 0);
        areset = 1'b0;
        idle(2);

        // Blank frame
        bus.min_count = 1;
        v0 = valid_seen;
        send_frame_wrap(0);
        check("blank valid pulses", valid_seen - v0, 1);
        expect_result("blank", 0, 0, 0, 0, 0, 0);

        // Three pixels, found and not found
        set_px(2, 1); set_px(5, 1); set_px(3, 4);
        bus.min_count = 3;
        send_frame_wrap(0);
`ifdef MOTION_BOX_NOISE_FILTER_EN
        expect_result("three", 0, 0, 0, 0, 0, 0);
`else
        expect_result("three", 2, 5, 1, 4, 3, 1);
        bus.min_count = 4;
        send_frame_wrap(0);
        expect_result("three_min4", 0, 0, 0, 0, 3, 0);
`endif

        // Abort at (3,2), then full frame with (7,5)
        a0 = abort_seen;
        v0 = valid_seen;
        send_pixels(19, 0);
        clear_mask(); set_px(7, 5); set_px(6, 5);
`ifndef MOTION_BOX_NOISE_FILTER_EN
        clear_mask(); set_px(7, 5);
`endif
        bus.min_count = 1;
        send_frame_wrap(0);
        check("abort pulses", abort_seen - a0, 1);
        check("abort valid pulses", valid_seen - v0, 1);
        expect_result("after_abort", 7, 7, 5, 5, 1, 1);

        // Abort at the final-pixel position
        a0 = abort_seen;
        v0 = valid_seen;
        send_pixels(N - 1, 0);
        send_frame_wrap(0);
        check("final-pos abort", abort_seen - a0, 1);
        check("final-pos valid", valid_seen - v0, 1);

        // Gaps, single pixel at (0,0)
        clear_mask(); set_px(0, 0);
        send_frame_wrap(3);
`ifdef MOTION_BOX_NOISE_FILTER_EN
        expect_result("gaps", 0, 0, 0, 0, 0, 0);
`else
        expect_result("gaps", 0, 0, 0, 0, 1, 1);
`endif

        // Isolated pixel, in-line run and run across a line wrap
        clear_mask();
        set_px(2, 1); set_px(4, 3); set_px(5, 3); set_px(7, 0); set_px(0, 1);
        send_frame_wrap(1);
`ifdef MOTION_BOX_NOISE_FILTER_EN
        expect_result("filter", 5, 5, 3, 3, 1, 1);
`else
        expect_result("nofilter", 0, 7, 0, 3, 5, 1);
`endif

        // Back-to-back frames
        v0 = valid_seen;
        send_pixels(N, 0);
        send_pixels(N, 0);
        idle(2);
        check("back-to-back valid", valid_seen - v0, 2);

        // Reset mid-frame discards the frame
        send_pixels(20, 1);
        v0 = valid_seen;
        areset = 1'b1;
        model_reset();
        idle(2);
        check("midreset valid", valid_seen - v0, 0);
        expect_result("midreset", 0, 0, 0, 0, 0, 0);
        areset = 1'b0;
        idle(1);

        // Randomized frames with gaps, aborts and varied thresholds
        for (int f = 0; f < 25; f++) begin
            int dens;
            dens = $urandom_range(0, 60);
            for (int i = 0; i < N; i++) frame_mask[i] = $urandom_range(0, 99) < dens;
            bus.min_count = NW'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) send_pixels($urandom_range(1, N - 1), 2);
            send_pixels(N, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic send_frame_wrap(int gap_max);
        send_pixels(N, gap_max);
        idle(2);
    endtask
endmodule

// File: doc/motion_box.md
# motion_box

Consumes the binary motion mask produced by the delta-frame stage and reports, once per frame, the bounding box and active-pixel count of detected motion. It sits at the read end of the delta-mask stream, after the delta stage and before the tracking/overlay logic. The tracker uses its per-frame result to place the object marker.

## Interface
Parameters:
- INPUT_WIDTH, 10, width of the incoming mask pixel
- FRAME_WIDTH, 640, active pixels per line
- FRAME_HEIGHT, 480, active lines per frame
- COORD_WIDTH, 10, coordinate width; must hold FRAME_WIDTH-1 and FRAME_HEIGHT-1
- COUNT_WIDTH, 20, active-pixel counter width

Ports:
- clk, input, 1, single clock; all logic on rising edge
- areset, input, 1, asynchronous active-high reset
- enable, input, 1, pixel strobe; pixel sampled only when high
- sof, input, 1, start of frame; qualified by enable, marks pixel (0,0)
- delta_pixel, input, INPUT_WIDTH, mask pixel; active when bit INPUT_WIDTH-1 is 1
- min_count, input, COUNT_WIDTH, minimum active pixels for a valid object
- box_x_min, output, COORD_WIDTH, leftmost active column
- box_x_max, output, COORD_WIDTH, rightmost active column
- box_y_min, output, COORD_WIDTH, top active line
- box_y_max, output, COORD_WIDTH, bottom active line
- box_count, output, COUNT_WIDTH, active pixels in last frame
- box_found, output, 1, box_count >= min_count for last frame
- box_valid, output, 1, one-cycle pulse when result outputs update
- frame_abort, output, 1, one-cycle pulse when a frame is restarted before completion

## Operation
- FSM states: IDLE, SCAN.
- IDLE: enable without sof is ignored. enable&sof → clear accumulators, process pixel as (0,0), go to SCAN, x=1, y=0.
- SCAN: each enable advances x; x wraps FRAME_WIDTH-1 → 0 and increments y.
- Accumulators: x_min/y_min init to all ones, x_max/y_max init to 0, count init 0. An active pixel updates min/max and increments count. Count saturates at all ones.
- Final pixel (x=FRAME_WIDTH-1, y=FRAME_HEIGHT-1) is folded into the result and loads the result registers:
  - box_count = count.
  - box_found = (count >= min_count).
  - If found, coordinates = accumulators; if not found, all four coordinates = 0.
  - Return to IDLE.
- min_count is sampled on the final-pixel edge only.
- sof with enable in SCAN, at any position including the final-pixel position:
  - Abort the current frame: no result update, frame_abort pulses.
  - Restart as at IDLE with the sof pixel as (0,0).
- Result registers hold their values until the next completed frame.

## Timing
- Reset: state IDLE, counters 0, all outputs 0.
- Reset asserted mid-frame: the frame is discarded and no box_valid is produced.
- Latency:
  - Result registers update on the edge sampling the final pixel.
  - box_valid is high for exactly the following cycle.
  - A back-to-back sof on the next cycle is accepted normally.
- frame_abort is high for the one cycle following the aborting sof edge.
- box_valid and frame_abort are never high together.
- Gaps: enable may drop for any number of cycles mid-frame. State and counters hold during gaps.

## Configuration
- MOTION_BOX_NOISE_FILTER_EN defined:
  - A pixel counts as active only if it and the previous sampled pixel in the same line both have bit INPUT_WIDTH-1 set.
  - Pixels at x=0 are never active.
  - The filtered pixel's own coordinate is used.
  - The previous-pixel register clears at sof and at line wrap.
- Not defined: each pixel is judged alone; no previous-pixel register.

## Test plan
All scenarios use FRAME_WIDTH=8, FRAME_HEIGHT=6.
- Reset, then a full frame of zeros with min_count=1 → box_valid pulses once; box_count=0, box_found=0, all coordinates 0.
- Frame with active pixels (2,1), (5,1), (3,4), min_count=3, filter off → box_x_min=2, box_x_max=5, box_y_min=1, box_y_max=4, box_count=3, box_found=1.
- Same frame with min_count=4 → box_count=3, box_found=0, coordinates 0.
- sof reasserted at pixel (3,2) of a frame, then a full frame with active pixel (7,5) → frame_abort pulses once; the next box_valid reports (7,7,5,5), box_count=1.
- Frame with random enable gaps of 0–3 cycles, active pixel (0,0) only → result identical to the gap-free run: box (0,0,0,0), box_count=1.
- Filter on: isolated active (2,1), plus run (4,3),(5,3) and run (7,0),(0,1) across a line wrap → box_count=1, box = (5,5,3,3).
